// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty sequencer family.
//   DUTY_W_DEF : default duty width, matching pwm_controller's duty input
//   US_PER_MS  : microsecond ticks per millisecond tick
//   state_t    : ramp sequencer state encoding
package pwm_pkg;
  localparam int DUTY_W_DEF = 7;
  localparam int US_PER_MS  = 1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/pwm_ms_tick.sv
// Millisecond tick generator: a SYS_FREQ-cycle microsecond prescaler feeding
// a US_PER_MS microsecond counter.
//   clk, reset_p : clock, synchronous active-high reset
//   clr          : synchronous clear of both prescalers (restart the ms period)
//   ms_tick      : one-cycle pulse every US_PER_MS * SYS_FREQ cycles after clr
module pwm_ms_tick
  import pwm_pkg::*;
#(
  parameter int SYS_FREQ = 125
) (
  input  logic clk,
  input  logic reset_p,
  input  logic clr,
  output logic ms_tick
);
  // SYS_FREQ=1 would give a zero-width counter; keep at least one bit.
  localparam int US_W = (SYS_FREQ > 1) ? $clog2(SYS_FREQ) : 1;
  localparam int MS_W = $clog2(US_PER_MS);

  logic [US_W-1:0] us_cnt;
  logic [MS_W-1:0] ms_cnt;
  logic            us_tick;

  assign us_tick = (us_cnt == US_W'(SYS_FREQ - 1));
  assign ms_tick = us_tick && (ms_cnt == MS_W'(US_PER_MS - 1));

  always_ff @(posedge clk) begin
    if (reset_p || clr) begin
      us_cnt <= '0;
      ms_cnt <= '0;
    end else if (us_tick) begin
      us_cnt <= '0;
      ms_cnt <= ms_tick ? '0 : ms_cnt + 1'b1;
    end else begin
      us_cnt <= us_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/pwm_duty_ramp.sv
// Soft-start / soft-stop duty sequencer in front of pwm_controller. Accepts a
// target duty and a per-LSB step period, then walks the live duty toward the
// target one LSB per step.
//   clk, reset_p          : clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake (ready only in IDLE)
//   cmd_duty, cmd_step_ms : target duty, ms per LSB step (0 = jump now)
//   abort                 : leave a ramp, holding the present duty
//   duty                  : registered live duty
//   busy                  : ramp in progress
//   done                  : one-cycle pulse when duty reaches the target
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int SYS_FREQ  = 125,
  parameter int DUTY_W    = DUTY_W_DEF,
  parameter int INIT_DUTY = 0
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic [7:0]        cmd_step_ms,
  input  logic              abort,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done
);
  state_t            state, state_n;
  logic [DUTY_W-1:0] target;
  logic [7:0]        step;
  logic [7:0]        step_cnt;
  logic              ms_tick;
  logic              imm;
  logic              step_hit;
  logic [DUTY_W-1:0] duty_nxt;

  // Prescalers free-run only while ramping, so every accept restarts the
  // first step period at zero.
  pwm_ms_tick #(.SYS_FREQ(SYS_FREQ)) u_ms_tick (
    .clk     (clk),
    .reset_p (reset_p),
    .clr     ((state != ST_RAMP) || abort),
    .ms_tick (ms_tick)
  );

  assign imm      = (cmd_duty == duty) || (cmd_step_ms == 8'd0);
  // step is never 0 in RAMP, so step-1 cannot wrap.
  assign step_hit = ms_tick && (step_cnt == step - 8'd1);
  // duty != target in RAMP, so neither direction can overshoot or wrap.
  assign duty_nxt = (duty < target) ? duty + 1'b1 : duty - 1'b1;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state == ST_RAMP);
  assign done      = (state == ST_DONE);

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (cmd_valid) state_n = imm ? ST_DONE : ST_RAMP;
      ST_RAMP: begin
        if (abort)                             state_n = ST_IDLE;
        else if (step_hit && duty_nxt == target) state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state    <= ST_IDLE;
      duty     <= DUTY_W'(INIT_DUTY);
      target   <= '0;
      step     <= '0;
      step_cnt <= '0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            target   <= cmd_duty;
            step     <= cmd_step_ms;
            step_cnt <= '0;
            // Immediate commands land the target on entry to DONE.
            if (imm) duty <= cmd_duty;
          end
        end
        ST_RAMP: begin
          if (abort) begin
            step_cnt <= '0;
          end else if (ms_tick) begin
            if (step_hit) begin
              step_cnt <= '0;
              duty     <= duty_nxt;
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp at SYS_FREQ=1 (1 ms = 1000 cycles).
module tb_pwm_duty_ramp;
  logic       clk = 1'b0;
  logic       reset_p;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_duty;
  logic [7:0] cmd_step_ms;
  logic       abort;
  logic [6:0] duty;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  pwm_duty_ramp #(.SYS_FREQ(1), .DUTY_W(7), .INIT_DUTY(0)) dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_duty    (cmd_duty),
    .cmd_step_ms (cmd_step_ms),
    .abort       (abort),
    .duty        (duty),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int s;
    int exp_duty;
    int exp_k;     // edges after accept until done is seen
    int exp_busy;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a command and return just after its accept edge.
  task automatic start_cmd(input int d, input int s);
    int w = 0;
    cmd_duty    = 7'(d);
    cmd_step_ms = 8'(s);
    cmd_valid   = 1'b1;
    while (!cmd_ready && w < 100) begin
      tick();
      w++;
    end
    if (w >= 100) check("cmd_ready_timeout", 0, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Per-cycle reference for a ramp that was accepted on the previous edge.
  task automatic trace(input string nm, input int st, input int tg, input int stp);
    int diff = (tg > st) ? tg - st : st - tg;
    int per  = stp * 1000;
    int dk   = diff * per;
    int bad  = 0;
    for (int k = 1; k <= dk + 1; k++) begin
      int m;
      int ed;
      tick();
      m  = k / per;
      if (m > diff) m = diff;
      ed = (tg >= st) ? st + m : st - m;
      if (duty !== 7'(ed))                  bad++;
      if (done !== (k == dk))               bad++;
      if (busy !== (k < dk))                bad++;
      if (cmd_ready !== (k > dk))           bad++;
      if (bad == 1 && k < 5) $display("  %s first bad cycle k=%0d", nm, k);
    end
    check(nm, bad, 0);
  endtask

  initial begin
    int k;
    int bseen;

    tbl[0] = '{d:100, s:0, exp_duty:100, exp_k:0,    exp_busy:0};
    tbl[1] = '{d:100, s:5, exp_duty:100, exp_k:0,    exp_busy:0};
    tbl[2] = '{d:127, s:0, exp_duty:127, exp_k:0,    exp_busy:0};
    tbl[3] = '{d:126, s:1, exp_duty:126, exp_k:1000, exp_busy:1};
    tbl[4] = '{d:127, s:1, exp_duty:127, exp_k:1000, exp_busy:1};
    tbl[5] = '{d:0,   s:0, exp_duty:0,   exp_k:0,    exp_busy:0};
    tbl[6] = '{d:1,   s:2, exp_duty:1,   exp_k:2000, exp_busy:1};

    reset_p = 1'b1; cmd_valid = 1'b0; cmd_duty = '0; cmd_step_ms = '0; abort = 1'b0;
    repeat (3) tick();
    reset_p = 1'b0;
    tick();
    check("rst_duty",  duty,      0);
    check("rst_busy",  busy,      0);
    check("rst_done",  done,      0);
    check("rst_ready", cmd_ready, 1);

    // Ramp up 0 -> 5, 2 ms per step.
    start_cmd(5, 2);
    check("up_busy_at_accept", busy, 1);
    trace("ramp_up", 0, 5, 2);

    // Ramp down 5 -> 2, 1 ms per step.
    start_cmd(2, 1);
    trace("ramp_down", 5, 2, 1);

    // Table of immediate and single-step commands.
    for (int i = 0; i < 7; i++) begin
      start_cmd(tbl[i].d, tbl[i].s);
      k = 0;
      bseen = busy;
      while (!done && k < 5000) begin
        tick();
        k++;
        bseen |= busy;
      end
      check($sformatf("tbl%0d_k", i),    k,     tbl[i].exp_k);
      check($sformatf("tbl%0d_duty", i), duty,  tbl[i].exp_duty);
      check($sformatf("tbl%0d_busy", i), bseen, tbl[i].exp_busy);
      tick();
      check($sformatf("tbl%0d_idle", i), {done, cmd_ready}, 1);
    end

    // Abort at duty=3 while ramping 1 -> 10.
    start_cmd(10, 1);
    k = 0;
    while (duty != 7'd3 && k < 5000) begin
      tick();
      k++;
    end
    check("abort_reach3", k, 2000);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_ready", cmd_ready, 1);
    check("abort_busy",  busy,      0);
    check("abort_duty",  duty,      3);
    bseen = done;
    repeat (1500) begin
      tick();
      bseen |= done;
    end
    check("abort_hold_duty", duty,  3);
    check("abort_no_done",   bseen, 0);
    // abort held alongside a command in IDLE must not block the accept.
    abort = 1'b1;
    start_cmd(3, 0);
    abort = 1'b0;
    check("post_abort_done", done, 1);
    tick();

    // Backpressure: a command held during a ramp is taken exactly once.
    start_cmd(5, 1);
    cmd_duty = 7'd1; cmd_step_ms = 8'd0; cmd_valid = 1'b1;
    trace("bp_ramp", 3, 5, 1);
    tick();
    cmd_valid = 1'b0;
    check("bp_accept_duty", duty, 1);
    check("bp_accept_done", done, 1);
    tick();
    check("bp_once_done",  done,      0);
    check("bp_once_ready", cmd_ready, 1);

    // Reset mid-ramp.
    start_cmd(20, 1);
    repeat (2500) tick();
    check("rst_mid_pre", duty, 3);
    reset_p = 1'b1;
    tick();
    check("rst_mid_duty",  duty,      0);
    check("rst_mid_busy",  busy,      0);
    check("rst_mid_ready", cmd_ready, 1);
    reset_p = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
